ram_copy_engine: RTL

//  Initiator/master for the dual-port synchronous RAM: block copy of LEN words src->dst inside one RAM.

---
 rtl/ram_copy_pkg.sv | 23 ++
 rtl/ram_copy_agen.sv | 44 ++++
 rtl/ram_copy_engine.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ram_copy_pkg.sv
// Shared FSM encoding and overlap check for the RAM block-copy engine.
package ram_copy_pkg;

  localparam int ST_W  = 2;
  localparam int OVL_W = 33;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // dst strictly inside (src, src+len) means a forward copy would clobber unread source words.
  function automatic logic dst_overlaps(input logic [OVL_W-1:0] src,
                                        input logic [OVL_W-1:0] dst,
                                        input logic [OVL_W-1:0] len);
    logic [OVL_W:0] src_end;
    src_end = {1'b0, src} + {1'b0, len};
    return (dst > src) && ({1'b0, dst} < src_end);
  endfunction

endpackage

// File: rtl/ram_copy_agen.sv
// Loadable address generator with remaining-word counter; last is high while one word remains.
module ram_copy_agen #(
  parameter int AW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] base,
  input  logic [CW-1:0] count,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = base;
      cnt_d  = count;
    end else if (inc) begin
      addr_d = addr_q + AW'(1);
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/ram_copy_engine.sv
// Block copy of len words src->dst inside one dual-port RAM, one word per clock.
// Optional checksum output enabled by defining RAM_COPY_CHECKSUM_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start; validates command
// ST_READ  | issuing reads src+i (writes of earlier words overlap)
// ST_DRAIN | last write only, read pipeline empty
// ST_FIN   | done pulse, then back to idle
module ram_copy_engine
  import ram_copy_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ram_cs,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic                  ram_oe_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic                  ram_we_b,
  output logic [DATA_WIDTH-1:0] ram_din_b
`ifdef RAM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  logic   cs_q, cs_d;
  logic   oe_q, oe_d;
  logic   we_q, we_d;
  logic   accept, rd_inc, rd_last, wr_last, overlap;

  assign overlap = dst_overlaps(OVL_W'(src_addr), OVL_W'(dst_addr), OVL_W'(len));

  ram_copy_agen #(.AW(ADDR_WIDTH), .CW(LEN_WIDTH)) u_rd_agen (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .inc   (rd_inc),
    .base  (src_addr),
    .count (len),
    .addr  (ram_addr_a),
    .last  (rd_last)
  );

  // Write side advances after each completed write, so it trails the read side by one clock.
  ram_copy_agen #(.AW(ADDR_WIDTH), .CW(LEN_WIDTH)) u_wr_agen (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .inc   (we_q),
    .base  (dst_addr),
    .count (len),
    .addr  (ram_addr_b),
    .last  (wr_last)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cs_d    = cs_q;
    oe_d    = oe_q;
    we_d    = oe_q;
    accept  = 1'b0;
    rd_inc  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = overlap;
          if (len != '0 && !overlap) begin
            accept  = 1'b1;
            state_d = ST_READ;
            busy_d  = 1'b1;
            cs_d    = 1'b0;
            oe_d    = 1'b1;
          end else begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (rd_last) begin
          oe_d    = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          rd_inc = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (wr_last) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef RAM_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (state_q == ST_IDLE && start) chk_d = '0;
    else if (we_q)                   chk_d = chk_q ^ ram_dout_a;
  end

  assign checksum = chk_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b1;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
`ifdef RAM_COPY_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
`ifdef RAM_COPY_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ram_cs    = cs_q;
  assign ram_oe_a  = oe_q;
  assign ram_we_b  = we_q;
  assign ram_din_b = ram_dout_a;

endmodule
